// File: rtl/trap_csr_pkg.sv
// Shared types for the trap/CSR block: CSR addresses, privilege encodings,
// the mstatus field layout and small helpers for packing and WARL fields.
package trap_csr_pkg;

    // CSR addresses
    localparam logic [11:0] CSR_SSTATUS  = 12'h100;
    localparam logic [11:0] CSR_STVEC    = 12'h105;
    localparam logic [11:0] CSR_SSCRATCH = 12'h140;
    localparam logic [11:0] CSR_SEPC     = 12'h141;
    localparam logic [11:0] CSR_SCAUSE   = 12'h142;
    localparam logic [11:0] CSR_STVAL    = 12'h143;
    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MEDELEG  = 12'h302;
    localparam logic [11:0] CSR_MIDELEG  = 12'h303;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MTVAL    = 12'h343;

    // Privilege levels
    typedef enum logic [1:0] {
        PRIV_U = 2'd0,
        PRIV_S = 2'd1,
        PRIV_M = 2'd3
    } priv_e;

    // sstatus view of mstatus: SIE | SPIE | SPP
    localparam logic [63:0] SSTATUS_MASK = 64'h0000_0000_0000_0122;
    // medeleg bit 11 (ecall from M) can never be delegated
    localparam logic [63:0] MEDELEG_MASK = ~64'h0000_0000_0000_0800;

    // Only the implemented mstatus fields are stored
    typedef struct packed {
        logic [1:0] mpp;
        logic       spp;
        logic       mpie;
        logic       spie;
        logic       mie;
        logic       sie;
    } mstatus_t;

    // Place the stored fields at their architectural bit positions
    function automatic logic [63:0] mstatus_to_word(input mstatus_t s);
        logic [63:0] w;
        w       = '0;
        w[1]    = s.sie;
        w[3]    = s.mie;
        w[5]    = s.spie;
        w[7]    = s.mpie;
        w[8]    = s.spp;
        w[12:11] = s.mpp;
        return w;
    endfunction

    // Trap-vector mode is WARL: reserved modes 2 and 3 collapse to direct
    function automatic logic [63:0] tvec_warl(input logic [63:0] v);
        return {v[63:2], (v[1:0] >= 2'd2) ? 2'b00 : v[1:0]};
    endfunction

endpackage

// File: rtl/trap_csr.sv
// Machine/supervisor trap CSR file: software CSR access, trap entry with
// delegation, mret/sret return, and the combinational trap-vector target.
module trap_csr
    import trap_csr_pkg::*;
#(
    parameter logic [63:0] mtvec_rst = 64'hc0000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        exception,
    input  logic [63:0] epc,
    input  logic [63:0] tval,
    input  logic [63:0] cause,
    input  logic [2:0]  eret,
    input  logic        csr_we,
    input  logic [11:0] csr_addr,
    input  logic [63:0] csr_wdata,
    output logic [63:0] csr_rdata,
    output logic [63:0] tvec,
    output logic [63:0] mepc,
    output logic [63:0] sepc,
    output logic [1:0]  priv
);

    priv_e       priv_reg, priv_next;
    mstatus_t    mstatus_reg, mstatus_next;
    logic [63:0] medeleg_reg, medeleg_next;
    logic [63:0] mideleg_reg, mideleg_next;
    logic [63:0] mtvec_reg, mtvec_next;
    logic [63:0] stvec_reg, stvec_next;
    logic [63:0] mscratch_reg, mscratch_next;
    logic [63:0] sscratch_reg, sscratch_next;
    logic [63:0] mepc_reg, mepc_next;
    logic [63:0] sepc_reg, sepc_next;
    logic [63:0] mcause_reg, mcause_next;
    logic [63:0] scause_reg, scause_next;
    logic [63:0] mtval_reg, mtval_next;
    logic [63:0] stval_reg, stval_next;

    logic        deleg;
    logic        unused_eret;

    assign unused_eret = eret[0];

    // Trap target: delegated traps use stvec, vectored mode offsets interrupts
    function automatic logic [63:0] trap_target(input logic        use_s,
                                                input logic [63:0] m_vec,
                                                input logic [63:0] s_vec,
                                                input logic [63:0] c);
        logic [63:0] sel;
        logic [63:0] base;
        sel  = use_s ? s_vec : m_vec;
        base = {sel[63:2], 2'b00};
        if (sel[1:0] == 2'b01 && c[63])
            base = base + {56'd0, c[5:0], 2'b00};
        return base;
    endfunction

    // Delegation decision and vector target for the current cause inputs
    always_comb begin
        deleg = 1'b0;
        if (priv_reg != PRIV_M)
            deleg = cause[63] ? mideleg_reg[cause[5:0]] : medeleg_reg[cause[5:0]];
        tvec = trap_target(deleg, mtvec_reg, stvec_reg, cause);
    end

    // Combinational CSR read; returns the pre-update state
    always_comb begin
        csr_rdata = '0;
        case (csr_addr)
            CSR_MSTATUS:  csr_rdata = mstatus_to_word(mstatus_reg);
            CSR_SSTATUS:  csr_rdata = mstatus_to_word(mstatus_reg) & SSTATUS_MASK;
            CSR_MEDELEG:  csr_rdata = medeleg_reg;
            CSR_MIDELEG:  csr_rdata = mideleg_reg;
            CSR_MTVEC:    csr_rdata = mtvec_reg;
            CSR_STVEC:    csr_rdata = stvec_reg;
            CSR_MSCRATCH: csr_rdata = mscratch_reg;
            CSR_SSCRATCH: csr_rdata = sscratch_reg;
            CSR_MEPC:     csr_rdata = mepc_reg;
            CSR_SEPC:     csr_rdata = sepc_reg;
            CSR_MCAUSE:   csr_rdata = mcause_reg;
            CSR_SCAUSE:   csr_rdata = scause_reg;
            CSR_MTVAL:    csr_rdata = mtval_reg;
            CSR_STVAL:    csr_rdata = stval_reg;
            default:      csr_rdata = '0;
        endcase
    end

    // Next state: software write first, then trap/return overrides the
    // fields it owns so a coincident write survives only in untouched fields
    always_comb begin
        priv_next     = priv_reg;
        mstatus_next  = mstatus_reg;
        medeleg_next  = medeleg_reg;
        mideleg_next  = mideleg_reg;
        mtvec_next    = mtvec_reg;
        stvec_next    = stvec_reg;
        mscratch_next = mscratch_reg;
        sscratch_next = sscratch_reg;
        mepc_next     = mepc_reg;
        sepc_next     = sepc_reg;
        mcause_next   = mcause_reg;
        scause_next   = scause_reg;
        mtval_next    = mtval_reg;
        stval_next    = stval_reg;

        if (csr_we) begin
            case (csr_addr)
                CSR_MSTATUS: begin
                    mstatus_next.sie  = csr_wdata[1];
                    mstatus_next.mie  = csr_wdata[3];
                    mstatus_next.spie = csr_wdata[5];
                    mstatus_next.mpie = csr_wdata[7];
                    mstatus_next.spp  = csr_wdata[8];
                    mstatus_next.mpp  = (csr_wdata[12:11] == 2'b10) ? 2'b00 : csr_wdata[12:11];
                end
                CSR_SSTATUS: begin
                    mstatus_next.sie  = csr_wdata[1];
                    mstatus_next.spie = csr_wdata[5];
                    mstatus_next.spp  = csr_wdata[8];
                end
                CSR_MEDELEG:  medeleg_next  = csr_wdata & MEDELEG_MASK;
                CSR_MIDELEG:  mideleg_next  = csr_wdata;
                CSR_MTVEC:    mtvec_next    = tvec_warl(csr_wdata);
                CSR_STVEC:    stvec_next    = tvec_warl(csr_wdata);
                CSR_MSCRATCH: mscratch_next = csr_wdata;
                CSR_SSCRATCH: sscratch_next = csr_wdata;
                CSR_MEPC:     mepc_next     = csr_wdata & ~64'd1;
                CSR_SEPC:     sepc_next     = csr_wdata & ~64'd1;
                CSR_MCAUSE:   mcause_next   = csr_wdata;
                CSR_SCAUSE:   scause_next   = csr_wdata;
                CSR_MTVAL:    mtval_next    = csr_wdata;
                CSR_STVAL:    stval_next    = csr_wdata;
                default: ;
            endcase
        end

        if (exception) begin
            if (!deleg) begin
                mepc_next         = epc & ~64'd1;
                mcause_next       = cause;
                mtval_next        = tval;
                mstatus_next.mpie = mstatus_reg.mie;
                mstatus_next.mie  = 1'b0;
                mstatus_next.mpp  = priv_reg;
                priv_next         = PRIV_M;
            end else begin
                sepc_next         = epc & ~64'd1;
                scause_next       = cause;
                stval_next        = tval;
                mstatus_next.spie = mstatus_reg.sie;
                mstatus_next.sie  = 1'b0;
                mstatus_next.spp  = priv_reg[0];
                priv_next         = PRIV_S;
            end
        end else if (eret[2]) begin
            if (eret[1]) begin
                priv_next         = priv_e'(mstatus_reg.mpp);
                mstatus_next.mie  = mstatus_reg.mpie;
                mstatus_next.mpie = 1'b1;
                mstatus_next.mpp  = 2'b00;
            end else begin
                priv_next         = priv_e'({1'b0, mstatus_reg.spp});
                mstatus_next.sie  = mstatus_reg.spie;
                mstatus_next.spie = 1'b1;
                mstatus_next.spp  = 1'b0;
            end
        end
    end

    // State registers; reset discards any update pending in the same cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            priv_reg     <= PRIV_M;
            mstatus_reg  <= '0;
            medeleg_reg  <= '0;
            mideleg_reg  <= '0;
            mtvec_reg    <= mtvec_rst;
            stvec_reg    <= mtvec_rst;
            mscratch_reg <= '0;
            sscratch_reg <= '0;
            mepc_reg     <= '0;
            sepc_reg     <= '0;
            mcause_reg   <= '0;
            scause_reg   <= '0;
            mtval_reg    <= '0;
            stval_reg    <= '0;
        end else begin
            priv_reg     <= priv_next;
            mstatus_reg  <= mstatus_next;
            medeleg_reg  <= medeleg_next;
            mideleg_reg  <= mideleg_next;
            mtvec_reg    <= mtvec_next;
            stvec_reg    <= stvec_next;
            mscratch_reg <= mscratch_next;
            sscratch_reg <= sscratch_next;
            mepc_reg     <= mepc_next;
            sepc_reg     <= sepc_next;
            mcause_reg   <= mcause_next;
            scause_reg   <= scause_next;
            mtval_reg    <= mtval_next;
            stval_reg    <= stval_next;
        end
    end

    assign mepc = mepc_reg;
    assign sepc = sepc_reg;
    assign priv = priv_reg;

endmodule

// File: tb/tb_trap_csr.sv
// Directed self-checking bench for trap_csr: reset, trap entry, delegation,
// vectored targets, returns, write collisions and reset during a trap.
module tb_trap_csr;

    logic        clk;
    logic        rst;
    logic        exception;
    logic [63:0] epc;
    logic [63:0] tval;
    logic [63:0] cause;
    logic [2:0]  eret;
    logic        csr_we;
    logic [11:0] csr_addr;
    logic [63:0] csr_wdata;
    logic [63:0] csr_rdata;
    logic [63:0] tvec;
    logic [63:0] mepc;
    logic [63:0] sepc;
    logic [1:0]  priv;

    int checks;
    int errors;
    logic [63:0] rd;

    trap_csr #(.mtvec_rst(64'hc0000000)) dut (
        .clk       (clk),
        .rst       (rst),
        .exception (exception),
        .epc       (epc),
        .tval      (tval),
        .cause     (cause),
        .eret      (eret),
        .csr_we    (csr_we),
        .csr_addr  (csr_addr),
        .csr_wdata (csr_wdata),
        .csr_rdata (csr_rdata),
        .tvec      (tvec),
        .mepc      (mepc),
        .sepc      (sepc),
        .priv      (priv)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One-cycle software write, driven from a falling edge
    task automatic csr_write(input logic [11:0] a, input logic [63:0] d);
        csr_addr  = a;
        csr_wdata = d;
        csr_we    = 1'b1;
        @(negedge clk);
        csr_we    = 1'b0;
        $display("tx write addr=%h data=%h", a, d);
    endtask

    // Combinational read sampled away from the clock edge
    task automatic csr_read(input logic [11:0] a, output logic [63:0] d);
        csr_addr = a;
        #1;
        d = csr_rdata;
        $display("tx read  addr=%h data=%h", a, d);
    endtask

    task automatic test_reset();
        $display("tx reset asserted");
        checks++; if (priv !== 2'd3) begin errors++; $display("FAIL reset_priv: got %0d expected 3", priv); end
        checks++; if (mepc !== 64'd0) begin errors++; $display("FAIL reset_mepc: got %h expected 0", mepc); end
        checks++; if (sepc !== 64'd0) begin errors++; $display("FAIL reset_sepc: got %h expected 0", sepc); end
        csr_read(12'h305, rd);
        checks++; if (rd !== 64'hc0000000) begin errors++; $display("FAIL reset_mtvec: got %h expected c0000000", rd); end
        csr_read(12'h105, rd);
        checks++; if (rd !== 64'hc0000000) begin errors++; $display("FAIL reset_stvec: got %h expected c0000000", rd); end
        csr_read(12'h300, rd);
        checks++; if (rd !== 64'd0) begin errors++; $display("FAIL reset_mstatus: got %h expected 0", rd); end
        csr_read(12'hf14, rd);
        checks++; if (rd !== 64'd0) begin errors++; $display("FAIL unimpl_read: got %h expected 0", rd); end
        rst = 1'b1;
        @(negedge clk);
        $display("tx reset released");
        checks++; if (priv !== 2'd3) begin errors++; $display("FAIL post_reset_priv: got %0d expected 3", priv); end
    endtask

    task automatic test_m_trap();
        csr_write(12'h300, 64'h8);
        csr_read(12'h300, rd);
        checks++; if (rd !== 64'h8) begin errors++; $display("FAIL mstatus_mie_set: got %h expected 8", rd); end
        exception = 1'b1; cause = 64'd2; epc = 64'h80001003; tval = 64'hdead;
        #1;
        checks++; if (tvec !== 64'hc0000000) begin errors++; $display("FAIL m_trap_tvec: got %h expected c0000000", tvec); end
        @(negedge clk);
        exception = 1'b0;
        $display("tx m-trap cause=2 epc=80001003");
        checks++; if (mepc !== 64'h80001002) begin errors++; $display("FAIL m_trap_mepc: got %h expected 80001002", mepc); end
        checks++; if (priv !== 2'd3) begin errors++; $display("FAIL m_trap_priv: got %0d expected 3", priv); end
        csr_read(12'h342, rd);
        checks++; if (rd !== 64'd2) begin errors++; $display("FAIL m_trap_mcause: got %h expected 2", rd); end
        csr_read(12'h343, rd);
        checks++; if (rd !== 64'hdead) begin errors++; $display("FAIL m_trap_mtval: got %h expected dead", rd); end
        csr_read(12'h300, rd);
        checks++; if (rd !== 64'h1880) begin errors++; $display("FAIL m_trap_mstatus: got %h expected 1880", rd); end
        @(negedge clk);
    endtask

    task automatic test_deleg();
        csr_write(12'h302, 64'hffff_ffff_ffff_ffff);
        csr_read(12'h302, rd);
        checks++; if (rd !== 64'hffff_ffff_ffff_f7ff) begin errors++; $display("FAIL medeleg_bit11: got %h expected fffffffffffff7ff", rd); end
        @(negedge clk);
        csr_write(12'h302, 64'h100);
        csr_write(12'h105, 64'h2000);
        csr_write(12'h300, 64'h1000);
        csr_read(12'h300, rd);
        checks++; if (rd !== 64'd0) begin errors++; $display("FAIL mpp_warl: got %h expected 0", rd); end
        @(negedge clk);
        eret = 3'b110;
        @(negedge clk);
        eret = 3'b000;
        $display("tx mret to MPP=0");
        checks++; if (priv !== 2'd0) begin errors++; $display("FAIL mret_priv: got %0d expected 0", priv); end
        csr_read(12'h300, rd);
        checks++; if (rd !== 64'h80) begin errors++; $display("FAIL mret_mstatus: got %h expected 80", rd); end
        exception = 1'b1; cause = 64'd8; epc = 64'h4000; tval = 64'h77;
        #1;
        checks++; if (tvec !== 64'h2000) begin errors++; $display("FAIL s_trap_tvec: got %h expected 2000", tvec); end
        @(negedge clk);
        exception = 1'b0;
        $display("tx s-trap cause=8 epc=4000");
        checks++; if (priv !== 2'd1) begin errors++; $display("FAIL s_trap_priv: got %0d expected 1", priv); end
        checks++; if (sepc !== 64'h4000) begin errors++; $display("FAIL s_trap_sepc: got %h expected 4000", sepc); end
        checks++; if (mepc !== 64'h80001002) begin errors++; $display("FAIL s_trap_mepc_kept: got %h expected 80001002", mepc); end
        csr_read(12'h142, rd);
        checks++; if (rd !== 64'd8) begin errors++; $display("FAIL s_trap_scause: got %h expected 8", rd); end
        csr_read(12'h143, rd);
        checks++; if (rd !== 64'h77) begin errors++; $display("FAIL s_trap_stval: got %h expected 77", rd); end
        csr_read(12'h300, rd);
        checks++; if (rd !== 64'h80) begin errors++; $display("FAIL s_trap_mstatus: got %h expected 80", rd); end
        @(negedge clk);
    endtask

    task automatic test_vectored();
        csr_write(12'h303, 64'h20);
        csr_write(12'h105, 64'h1001);
        csr_read(12'h105, rd);
        checks++; if (rd !== 64'h1001) begin errors++; $display("FAIL stvec_mode1: got %h expected 1001", rd); end
        exception = 1'b1; cause = 64'h8000_0000_0000_0005; epc = 64'h6001; tval = 64'h0;
        #1;
        checks++; if (tvec !== 64'h1014) begin errors++; $display("FAIL vectored_tvec: got %h expected 1014", tvec); end
        @(negedge clk);
        exception = 1'b0;
        $display("tx s-interrupt cause=8000000000000005");
        checks++; if (sepc !== 64'h6000) begin errors++; $display("FAIL irq_sepc: got %h expected 6000", sepc); end
        checks++; if (priv !== 2'd1) begin errors++; $display("FAIL irq_priv: got %0d expected 1", priv); end
        csr_read(12'h142, rd);
        checks++; if (rd !== 64'h8000_0000_0000_0005) begin errors++; $display("FAIL irq_scause: got %h expected 8000000000000005", rd); end
        csr_read(12'h100, rd);
        checks++; if (rd !== 64'h100) begin errors++; $display("FAIL irq_sstatus: got %h expected 100", rd); end
        cause = 64'h8000_0000_0000_0007;
        #1;
        checks++; if (tvec !== 64'hc0000000) begin errors++; $display("FAIL undeleg_irq_tvec: got %h expected c0000000", tvec); end
        cause = 64'd0;
        @(negedge clk);
        csr_write(12'h105, 64'h2003);
        csr_read(12'h105, rd);
        checks++; if (rd !== 64'h2000) begin errors++; $display("FAIL stvec_mode3: got %h expected 2000", rd); end
        @(negedge clk);
        csr_write(12'h105, 64'h3002);
        csr_read(12'h105, rd);
        checks++; if (rd !== 64'h3000) begin errors++; $display("FAIL stvec_mode2: got %h expected 3000", rd); end
        @(negedge clk);
    endtask

    task automatic test_sret();
        csr_write(12'h100, 64'hffff_ffff_ffff_ffff);
        csr_read(12'h300, rd);
        checks++; if (rd !== 64'h1a2) begin errors++; $display("FAIL sstatus_mask: got %h expected 1a2", rd); end
        @(negedge clk);
        eret = 3'b100;
        @(negedge clk);
        eret = 3'b000;
        $display("tx sret SPP=1");
        checks++; if (priv !== 2'd1) begin errors++; $display("FAIL sret1_priv: got %0d expected 1", priv); end
        csr_read(12'h300, rd);
        checks++; if (rd !== 64'ha2) begin errors++; $display("FAIL sret1_mstatus: got %h expected a2", rd); end
        @(negedge clk);
        csr_write(12'h100, 64'h0);
        eret = 3'b101;
        @(negedge clk);
        eret = 3'b000;
        $display("tx sret SPP=0");
        checks++; if (priv !== 2'd0) begin errors++; $display("FAIL sret0_priv: got %0d expected 0", priv); end
        csr_read(12'h300, rd);
        checks++; if (rd !== 64'ha0) begin errors++; $display("FAIL sret0_mstatus: got %h expected a0", rd); end
        @(negedge clk);
    endtask

    task automatic test_trap_csr_collision();
        exception = 1'b1; cause = 64'd3; epc = 64'h5000; tval = 64'h0;
        csr_we = 1'b1; csr_addr = 12'h341; csr_wdata = 64'h1234;
        #1;
        checks++; if (tvec !== 64'hc0000000) begin errors++; $display("FAIL coll_tvec: got %h expected c0000000", tvec); end
        @(negedge clk);
        exception = 1'b0; csr_we = 1'b0;
        $display("tx m-trap cause=3 with mepc write");
        checks++; if (mepc !== 64'h5000) begin errors++; $display("FAIL coll_mepc: got %h expected 5000", mepc); end
        checks++; if (priv !== 2'd3) begin errors++; $display("FAIL coll_priv: got %0d expected 3", priv); end
        csr_read(12'h342, rd);
        checks++; if (rd !== 64'd3) begin errors++; $display("FAIL coll_mcause: got %h expected 3", rd); end
        csr_read(12'h300, rd);
        checks++; if (rd !== 64'h20) begin errors++; $display("FAIL coll_mstatus: got %h expected 20", rd); end
        @(negedge clk);
        exception = 1'b1; cause = 64'd2; epc = 64'h7000;
        csr_we = 1'b1; csr_addr = 12'h100; csr_wdata = 64'h2;
        @(negedge clk);
        exception = 1'b0; csr_we = 1'b0;
        $display("tx m-trap cause=2 with sstatus write");
        csr_read(12'h300, rd);
        checks++; if (rd !== 64'h1802) begin errors++; $display("FAIL coll_sie_kept: got %h expected 1802", rd); end
        checks++; if (mepc !== 64'h7000) begin errors++; $display("FAIL coll2_mepc: got %h expected 7000", mepc); end
        @(negedge clk);
    endtask

    task automatic test_mret_csr();
        csr_write(12'h341, 64'h1235);
        checks++; if (mepc !== 64'h1234) begin errors++; $display("FAIL mepc_bit0: got %h expected 1234", mepc); end
        csr_write(12'h300, 64'h800);
        eret = 3'b110;
        csr_we = 1'b1; csr_addr = 12'h340; csr_wdata = 64'd5;
        @(negedge clk);
        eret = 3'b000; csr_we = 1'b0;
        $display("tx mret with mscratch write");
        checks++; if (priv !== 2'd1) begin errors++; $display("FAIL mret_csr_priv: got %0d expected 1", priv); end
        csr_read(12'h340, rd);
        checks++; if (rd !== 64'd5) begin errors++; $display("FAIL mret_csr_mscratch: got %h expected 5", rd); end
        csr_read(12'h300, rd);
        checks++; if (rd !== 64'h80) begin errors++; $display("FAIL mret_csr_mstatus: got %h expected 80", rd); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_trap();
        exception = 1'b1; cause = 64'd2; epc = 64'h9000; tval = 64'h11;
        #2;
        rst = 1'b0;
        #1;
        checks++; if (priv !== 2'd3) begin errors++; $display("FAIL rst_async_priv: got %0d expected 3", priv); end
        @(negedge clk);
        exception = 1'b0;
        $display("tx reset during m-trap");
        checks++; if (mepc !== 64'd0) begin errors++; $display("FAIL rst_mepc: got %h expected 0", mepc); end
        checks++; if (sepc !== 64'd0) begin errors++; $display("FAIL rst_sepc: got %h expected 0", sepc); end
        csr_read(12'h342, rd);
        checks++; if (rd !== 64'd0) begin errors++; $display("FAIL rst_mcause: got %h expected 0", rd); end
        csr_read(12'h340, rd);
        checks++; if (rd !== 64'd0) begin errors++; $display("FAIL rst_mscratch: got %h expected 0", rd); end
        csr_read(12'h300, rd);
        checks++; if (rd !== 64'd0) begin errors++; $display("FAIL rst_mstatus: got %h expected 0", rd); end
        csr_read(12'h105, rd);
        checks++; if (rd !== 64'hc0000000) begin errors++; $display("FAIL rst_stvec: got %h expected c0000000", rd); end
        csr_read(12'h302, rd);
        checks++; if (rd !== 64'd0) begin errors++; $display("FAIL rst_medeleg: got %h expected 0", rd); end
        rst = 1'b1;
        @(negedge clk);
        $display("tx reset released");
        checks++; if (mepc !== 64'd0) begin errors++; $display("FAIL rst_release_mepc: got %h expected 0", mepc); end
        checks++; if (priv !== 2'd3) begin errors++; $display("FAIL rst_release_priv: got %0d expected 3", priv); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        exception = 1'b0;
        epc = '0;
        tval = '0;
        cause = '0;
        eret = 3'b000;
        csr_we = 1'b0;
        csr_addr = '0;
        csr_wdata = '0;
        @(negedge clk);
        test_reset();
        test_m_trap();
        test_deleg();
        test_vectored();
        test_sret();
        test_trap_csr_collision();
        test_mret_csr();
        test_reset_mid_trap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
